shift_unit_p: RTL

- Parametrised multi-cycle shifter for the RV052B execute stage.
- Successor to the fixed 32-bit SHIFT unit, with the same start/done handshake.
- Generalised in data width and bits-shifted-per-cycle.
- Adds rotate modes, an explicit busy flag and an illegal-mode error flag.

---
 rtl/shift_unit_p.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/shift_unit_p.sv
// Parametrised multi-cycle shifter (SLL/SRL/SRA/ROL/ROR) with start/done handshake.
// Latency: done rises ceil(amt/STEP) cycles after the accept edge (same edge for amt=0 or illegal op).
// Backpressure: start is sampled only while idle; requests while busy are dropped.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   start         request strobe, sampled only in IDLE
//   op1           value to shift
//   op2/imm_data  shift-amount sources, only the low SHAMT_W bits are used
//   src_sel       0 selects op2, 1 selects imm_data
//   op_mode       000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   busy          high while an operation is in flight
//   done          one-cycle completion pulse, res valid from this cycle
//   err           qualified by done, flags an illegal op_mode
//   res           result register, held until the next done
module shift_unit_p #(
    parameter int XLEN    = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] imm_data,
    input  logic            src_sel,
    input  logic [2:0]      op_mode,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] res
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // One extra bit so STEP == XLEN is representable.
    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(STEP);

    state_t              state_q, state_d;
    logic [XLEN-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]  rem_q, rem_d;
    logic [2:0]          mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic [SHAMT_W-1:0]  amt_sel;
    logic                illegal;
    logic [SHAMT_W-1:0]  step_amt;
    logic [SHAMT_W-1:0]  rem_next;
    logic [2*XLEN-1:0]   dbl_l, dbl_r;
    logic [XLEN-1:0]     shifted;

    // Upper amount bits are masked off by design, never saturated.
    logic unused_amt_bits;
    assign unused_amt_bits = ^{op2[XLEN-1:SHAMT_W], imm_data[XLEN-1:SHAMT_W]};

    assign amt_sel = src_sel ? imm_data[SHAMT_W-1:0] : op2[SHAMT_W-1:0];
    assign illegal = (op_mode > OP_ROR);

    // Final partial step shifts by exactly the remainder. When STEP == XLEN the
    // remainder is always below STEP, so the truncated STEP_C is never selected.
    always_comb begin
        step_amt = STEP_C[SHAMT_W-1:0];
        if ({1'b0, rem_q} < STEP_C) begin
            step_amt = rem_q;
        end
    end

    assign rem_next = rem_q - step_amt;

    // Rotates via a doubled word: the bits shifted out of one copy come in from the other.
    always_comb begin
        dbl_l   = {work_q, work_q} << step_amt;
        dbl_r   = {work_q, work_q} >> step_amt;
        shifted = work_q;
        case (mode_q)
            OP_SLL:  shifted = work_q << step_amt;
            OP_SRL:  shifted = work_q >> step_amt;
            // Sign bit of the working register is the latched op1 MSB throughout.
            OP_SRA:  shifted = $signed(work_q) >>> step_amt;
            OP_ROL:  shifted = dbl_l[2*XLEN-1:XLEN];
            OP_ROR:  shifted = dbl_r[XLEN-1:0];
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        res_d   = res_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = op1;
                    mode_d = op_mode;
                    rem_d  = amt_sel;
                    if (illegal || (amt_sel == '0)) begin
                        res_d  = op1;
                        done_d = 1'b1;
                        err_d  = illegal;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                work_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    res_d   = shifted;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign res  = res_q;

endmodule
